// File: rtl/adc_resp_pkg.sv
// Shared constants and helpers for the ADC serial responder.
package adc_resp_pkg;

  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 12;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int CH_W       = 3;
  localparam int CNT_W      = 5;

  // SCLK rising-edge numbers (1-based) that carry ADD2, ADD1, ADD0
  localparam logic [CNT_W-1:0] ADD2_EDGE = 5'd3;
  localparam logic [CNT_W-1:0] ADD1_EDGE = 5'd4;
  localparam logic [CNT_W-1:0] ADD0_EDGE = 5'd5;
  localparam logic [CNT_W-1:0] LAST_EDGE = 5'd16;

  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_W-1:0] data);
    return {{LEAD_ZEROS{1'b0}}, data};
  endfunction

endpackage

// File: rtl/adc_resp_sync.sv
// Two-flop synchronizer with rise/fall detection on the synchronized value.
module adc_resp_sync #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= IDLE;
      sync_r <= IDLE;
      prev_r <= IDLE;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign q    = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/adc_responder.sv
// Slave-side model of a 16-bit-frame serial ADC serving an 8-channel value bank.
// Optional feature macro ADC_RESP_RAMP_EN: auto-increment the transmitted entry per frame.
module adc_responder
  import adc_resp_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic              ADC_CS_N,
  input  logic              ADC_SCLK,
  input  logic              ADC_SADDR,
  output logic              ADC_SDAT,
  output logic              sdat_oe,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic [CH_W-1:0]   last_addr
);

`ifdef ADC_RESP_RAMP_EN
  localparam logic RAMP_EN = 1'b1;
`else
  localparam logic RAMP_EN = 1'b0;
`endif

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic saddr_q, saddr_rise, saddr_fall;
  logic unused_s;

  adc_resp_sync #(.IDLE(1'b1)) u_sync_cs (
    .clk(CLOCK_50), .rst(RST), .din(ADC_CS_N),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  adc_resp_sync #(.IDLE(1'b1)) u_sync_sclk (
    .clk(CLOCK_50), .rst(RST), .din(ADC_SCLK),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  adc_resp_sync #(.IDLE(1'b0)) u_sync_saddr (
    .clk(CLOCK_50), .rst(RST), .din(ADC_SADDR),
    .q(saddr_q), .rise(saddr_rise), .fall(saddr_fall)
  );

  assign unused_s = ^{sclk_q, saddr_rise, saddr_fall};

  logic [DATA_W-1:0]     bank_r [NUM_CH];
  logic [DATA_W-1:0]     bank_s [NUM_CH];
  logic [FRAME_BITS-1:0] sr_r, sr_s;
  logic [CNT_W-1:0]      rise_cnt_r, rise_cnt_s, rise_n_s;
  logic [CNT_W-1:0]      fall_cnt_r, fall_cnt_s, fall_n_s;
  logic [CH_W-1:0]       addr_cap_r, addr_cap_s;
  logic [CH_W-1:0]       cur_addr_r, cur_addr_s;
  logic [CH_W-1:0]       last_addr_r, last_addr_s;
  logic                  done_r, done_s;

  // frame sequencing, address capture and bank update
  always_comb begin
    bank_s      = bank_r;
    sr_s        = sr_r;
    rise_cnt_s  = rise_cnt_r;
    fall_cnt_s  = fall_cnt_r;
    addr_cap_s  = addr_cap_r;
    cur_addr_s  = cur_addr_r;
    last_addr_s = last_addr_r;
    done_s      = 1'b0;
    rise_n_s    = rise_cnt_r + 5'd1;
    fall_n_s    = fall_cnt_r + 5'd1;

    if (cs_fall) begin
      sr_s       = frame_word(bank_r[cur_addr_r]);
      rise_cnt_s = 5'd0;
      fall_cnt_s = 5'd0;
      addr_cap_s = 3'd0;
    end else if (cs_rise) begin
      rise_cnt_s = 5'd0;
      fall_cnt_s = 5'd0;
    end else if (!cs_q) begin
      if (sclk_fall) begin
        // 16th falling edge reloads so a held-low CS_N streams without a gap
        if (fall_n_s == LAST_EDGE) begin
          sr_s       = frame_word(bank_r[cur_addr_r]);
          fall_cnt_s = 5'd0;
        end else begin
          sr_s       = {sr_r[FRAME_BITS-2:0], 1'b0};
          fall_cnt_s = fall_n_s;
        end
      end else begin
        fall_cnt_s = fall_cnt_r;
      end

      if (sclk_rise) begin
        case (rise_n_s)
          ADD2_EDGE: begin
            addr_cap_s[2] = saddr_q;
            rise_cnt_s    = rise_n_s;
          end
          ADD1_EDGE: begin
            addr_cap_s[1] = saddr_q;
            rise_cnt_s    = rise_n_s;
          end
          ADD0_EDGE: begin
            addr_cap_s[0] = saddr_q;
            rise_cnt_s    = rise_n_s;
          end
          LAST_EDGE: begin
            done_s      = 1'b1;
            cur_addr_s  = addr_cap_r;
            last_addr_s = addr_cap_r;
            rise_cnt_s  = 5'd0;
          end
          default: begin
            rise_cnt_s = rise_n_s;
          end
        endcase
      end else begin
        rise_cnt_s = rise_cnt_r;
      end
    end else begin
      sr_s = sr_r;
    end

    // ramp is applied first so that a same-cycle host write wins
    if (RAMP_EN && done_s) begin
      bank_s[cur_addr_r] = bank_r[cur_addr_r] + {{(DATA_W-CH_W){1'b0}}, cur_addr_r} + 12'd1;
    end else begin
      bank_s[cur_addr_r] = bank_r[cur_addr_r];
    end

    if (wr_en) begin
      bank_s[wr_ch] = wr_data;
    end else begin
      bank_s[wr_ch] = bank_s[wr_ch];
    end
  end

  // state registers
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bank_r[i] <= {DATA_W{1'b0}};
      end
      sr_r        <= {FRAME_BITS{1'b0}};
      rise_cnt_r  <= 5'd0;
      fall_cnt_r  <= 5'd0;
      addr_cap_r  <= 3'd0;
      cur_addr_r  <= 3'd0;
      last_addr_r <= 3'd0;
      done_r      <= 1'b0;
    end else begin
      bank_r      <= bank_s;
      sr_r        <= sr_s;
      rise_cnt_r  <= rise_cnt_s;
      fall_cnt_r  <= fall_cnt_s;
      addr_cap_r  <= addr_cap_s;
      cur_addr_r  <= cur_addr_s;
      last_addr_r <= last_addr_s;
      done_r      <= done_s;
    end
  end

  assign sdat_oe    = ~cs_q;
  assign ADC_SDAT   = sdat_oe & sr_r[FRAME_BITS-1];
  assign frame_done = done_r;
  assign last_addr  = last_addr_r;

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: frames, continuous mode, abort, reset and (with ADC_RESP_RAMP_EN) ramp.
module tb_adc_responder;

  localparam int H = 5;

  logic        clk;
  logic        rst;
  logic        cs_n;
  logic        sclk;
  logic        saddr;
  logic        sdat;
  logic        oe;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic        done;
  logic [2:0]  last;

  int tests_run;
  int tests_failed;
  int done_cnt;
  int d0;
  logic [31:0] bits;

  adc_responder dut (
    .CLOCK_50  (clk),
    .RST       (rst),
    .ADC_CS_N  (cs_n),
    .ADC_SCLK  (sclk),
    .ADC_SADDR (saddr),
    .ADC_SDAT  (sdat),
    .sdat_oe   (oe),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .frame_done(done),
    .last_addr (last)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [2:0] ch, input logic [11:0] data);
    wr_en = 1'b1; wr_ch = ch; wr_data = data;
    idle(1);
    wr_en = 1'b0;
  endtask

  // Reads DOUT just before each falling edge; ADD2..ADD0 driven ahead of rises 3..5.
  task automatic sclk_bits(input int n, input logic [2:0] addr, output logic [31:0] b);
    b = 32'd0;
    for (int k = 0; k < n; k++) begin
      b = {b[30:0], sdat};
      sclk = 1'b0;
      case (k % 16)
        2:       saddr = addr[2];
        3:       saddr = addr[1];
        4:       saddr = addr[0];
        default: saddr = 1'b0;
      endcase
      idle(H);
      sclk = 1'b1;
      idle(H);
    end
  endtask

  task automatic frame(input logic [2:0] addr, output logic [31:0] b);
    cs_n = 1'b0;
    idle(6);
    sclk_bits(16, addr, b);
    idle(4);
    cs_n = 1'b1;
    idle(6);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; done_cnt = 0;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; saddr = 1'b0;
    wr_en = 1'b0; wr_ch = 3'd0; wr_data = 12'd0;
    idle(3);
    check_eq("rst_sdat", {31'd0, sdat}, 32'd0);
    check_eq("rst_oe", {31'd0, oe}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_last", {29'd0, last}, 32'd0);
    rst = 1'b0;
    idle(3);

`ifdef ADC_RESP_RAMP_EN
    write(3'd2, 12'hFFE);
    frame(3'd2, bits);
    check_eq("ramp_setup", bits, 32'h0000_0000);
    frame(3'd2, bits);
    check_eq("ramp_s1", bits, 32'h0000_0FFE);
    frame(3'd2, bits);
    check_eq("ramp_s2", bits, 32'h0000_0001);
    frame(3'd2, bits);
    check_eq("ramp_s3", bits, 32'h0000_0004);
    check_eq("ramp_last", {29'd0, last}, 32'd2);
    check_eq("ramp_done_cnt", done_cnt, 32'd4);
`else
    // single frame, channel 0
    write(3'd0, 12'hABC);
    cs_n = 1'b0;
    idle(6);
    check_eq("oe_in_frame", {31'd0, oe}, 32'd1);
    d0 = done_cnt;
    sclk_bits(16, 3'd0, bits);
    idle(4);
    check_eq("f1_dout", bits, 32'h0000_0ABC);
    check_eq("f1_done", done_cnt - d0, 32'd1);
    check_eq("f1_last", {29'd0, last}, 32'd0);
    cs_n = 1'b1;
    idle(6);
    check_eq("oe_idle", {31'd0, oe}, 32'd0);
    check_eq("sdat_idle", {31'd0, sdat}, 32'd0);

    // address chosen in one frame selects the next frame's channel
    write(3'd5, 12'h123);
    frame(3'd5, bits);
    check_eq("f2a_dout", bits, 32'h0000_0ABC);
    check_eq("f2a_last", {29'd0, last}, 32'd5);
    frame(3'd0, bits);
    check_eq("f2b_dout", bits, 32'h0000_0123);
    check_eq("f2b_last", {29'd0, last}, 32'd0);

    // continuous mode: 32 SCLK with CS_N held low
    d0 = done_cnt;
    cs_n = 1'b0;
    idle(6);
    sclk_bits(32, 3'd0, bits);
    idle(4);
    cs_n = 1'b1;
    idle(6);
    check_eq("cont_dout", bits, 32'h0ABC_0ABC);
    check_eq("cont_done", done_cnt - d0, 32'd2);

    // abort after 9 SCLK: cur_addr stays 5
    frame(3'd5, bits);
    d0 = done_cnt;
    cs_n = 1'b0;
    idle(6);
    sclk_bits(9, 3'd3, bits);
    cs_n = 1'b1;
    idle(6);
    check_eq("abort_bits", bits, 32'h0000_0002);
    check_eq("abort_done", done_cnt - d0, 32'd0);
    check_eq("abort_oe", {31'd0, oe}, 32'd0);
    check_eq("abort_last", {29'd0, last}, 32'd5);
    frame(3'd0, bits);
    check_eq("after_abort_dout", bits, 32'h0000_0123);

    // write to the entry being loaded in the same cycle: old value goes out
    cs_n = 1'b0;
    idle(2);
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 12'h555;
    idle(1);
    wr_en = 1'b0;
    idle(3);
    sclk_bits(16, 3'd0, bits);
    idle(4);
    cs_n = 1'b1;
    idle(6);
    check_eq("wr_load_old", bits, 32'h0000_0ABC);
    frame(3'd0, bits);
    check_eq("wr_load_new", bits, 32'h0000_0555);

    // reset in the middle of a frame
    write(3'd6, 12'hFFF);
    frame(3'd6, bits);
    check_eq("pre_rst_last", {29'd0, last}, 32'd6);
    cs_n = 1'b0;
    idle(6);
    sclk_bits(7, 3'd0, bits);
    check_eq("pre_rst_bits", bits, 32'h0000_0007);
    check_eq("pre_rst_sdat", {31'd0, sdat}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_sdat", {31'd0, sdat}, 32'd0);
    check_eq("mid_rst_oe", {31'd0, oe}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_last", {29'd0, last}, 32'd0);
    idle(2);
    cs_n = 1'b1; sclk = 1'b1; saddr = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);
    frame(3'd6, bits);
    check_eq("post_rst_dout", bits, 32'h0000_0000);
    frame(3'd0, bits);
    check_eq("post_rst_bank", bits, 32'h0000_0000);
    check_eq("post_rst_last", {29'd0, last}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
